// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;
  localparam int DELAY_DEF  = 2;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_e;
  typedef enum logic {REQ_IFU, REQ_LSU} req_id_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// IFU/LSU request-response and memory port bundle for mem_arbiter.
// slave = arbiter side, master = requesters + memory model side.
interface mem_arbiter_if #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W_DEF,
  parameter int DATA_W = mem_arb_pkg::DATA_W_DEF
) ();
  logic                  ifu_req_valid;
  logic                  ifu_req_ready;
  logic [ADDR_W-1:0]     ifu_addr;
  logic                  ifu_resp_valid;
  logic [DATA_W-1:0]     ifu_resp_data;

  logic                  lsu_req_valid;
  logic                  lsu_req_ready;
  logic                  lsu_wen;
  logic [ADDR_W-1:0]     lsu_addr;
  logic [DATA_W-1:0]     lsu_wdata;
  logic [DATA_W/8-1:0]   lsu_wmask;
  logic                  lsu_resp_valid;
  logic [DATA_W-1:0]     lsu_resp_data;

  logic                  mem_ren;
  logic                  mem_wen;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W/8-1:0]   mem_wmask;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
    input  mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_data,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_data,
    output mem_ren, mem_wen, mem_addr, mem_wmask, mem_wdata
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
    output mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_data,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_data,
    input  mem_ren, mem_wen, mem_addr, mem_wmask, mem_wdata
  );
endinterface

// File: rtl/mem_arb_rr.sv
// 2-way round-robin picker: a lone requester wins, a tie goes to the
// requester that did not win last time. grant[0] = IFU, grant[1] = LSU.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic       ifu_valid,
  input  logic       lsu_valid,
  input  req_id_e    last_grant,
  output logic [1:0] grant
);

  // Pick one-hot winner
  always_comb begin
    grant = 2'b00;
    if (ifu_valid && lsu_valid)
      grant = (last_grant == REQ_LSU) ? 2'b01 : 2'b10;
    else
      grant = {lsu_valid, ifu_valid};
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one combinational memory port between IFU
// (read-only) and LSU (read/write). One access per handshake, memory
// enables high only in ACCESS, one-cycle response pulse the cycle after.
// Optional macro MEM_ARB_DELAY_EN inserts DELAY wait cycles before ACCESS.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DELAY  = DELAY_DEF
) (
  input  logic           clock,
  input  logic           reset,
  mem_arbiter_if.slave   bus
);

  localparam int MASK_W = DATA_W / 8;

  state_e              state_q, state_d;
  req_id_e             last_q, last_d;
  req_id_e             id_q, id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic                ifu_rv_q, ifu_rv_d;
  logic [DATA_W-1:0]   ifu_rd_q, ifu_rd_d;
  logic                lsu_rv_q, lsu_rv_d;
  logic [DATA_W-1:0]   lsu_rd_q, lsu_rd_d;
  logic [1:0]          grant;

`ifdef MEM_ARB_DELAY_EN
  localparam int CNT_W = (DELAY > 1) ? $clog2(DELAY) : 1;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`else
  logic [31:0]         unused_delay;
  assign unused_delay = 32'(DELAY);
`endif

  mem_arb_rr u_rr (
    .ifu_valid  (bus.ifu_req_valid),
    .lsu_valid  (bus.lsu_req_valid),
    .last_grant (last_q),
    .grant      (grant)
  );

  assign bus.ifu_resp_valid = ifu_rv_q;
  assign bus.ifu_resp_data  = ifu_rd_q;
  assign bus.lsu_resp_valid = lsu_rv_q;
  assign bus.lsu_resp_data  = lsu_rd_q;

  // Next state, request latch, memory drive and response capture
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    addr_d    = addr_q;
    wen_d     = wen_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    ifu_rv_d  = 1'b0;
    ifu_rd_d  = ifu_rd_q;
    lsu_rv_d  = 1'b0;
    lsu_rd_d  = lsu_rd_q;
`ifdef MEM_ARB_DELAY_EN
    cnt_d     = cnt_q;
`endif
    bus.ifu_req_ready = 1'b0;
    bus.lsu_req_ready = 1'b0;
    bus.mem_ren       = 1'b0;
    bus.mem_wen       = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_wmask     = '0;
    bus.mem_wdata     = '0;

    case (state_q)
      IDLE: begin
        // ready is combinational from valid; held low while in reset
        bus.ifu_req_ready = grant[0] & ~reset;
        bus.lsu_req_ready = grant[1] & ~reset;
        if (|grant) begin
          id_d    = grant[1] ? REQ_LSU : REQ_IFU;
          last_d  = grant[1] ? REQ_LSU : REQ_IFU;
          addr_d  = grant[1] ? bus.lsu_addr : bus.ifu_addr;
          wen_d   = grant[1] & bus.lsu_wen;
          wdata_d = grant[1] ? bus.lsu_wdata : '0;
          wmask_d = grant[1] ? bus.lsu_wmask : '0;
          state_d = ACCESS;
`ifdef MEM_ARB_DELAY_EN
          if (DELAY > 0) begin
            state_d = WAIT;
            cnt_d   = '0;
          end
`endif
        end
      end
`ifdef MEM_ARB_DELAY_EN
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DELAY - 1))
          state_d = ACCESS;
      end
`endif
      ACCESS: begin
        bus.mem_addr = addr_q;
        if (wen_q) begin
          bus.mem_wen   = 1'b1;
          bus.mem_wmask = wmask_q;
          bus.mem_wdata = wdata_q;
        end else begin
          bus.mem_ren = 1'b1;
        end
        if (id_q == REQ_IFU) begin
          ifu_rv_d = 1'b1;
          ifu_rd_d = bus.mem_rdata;
        end else begin
          lsu_rv_d = 1'b1;
          lsu_rd_d = wen_q ? '0 : bus.mem_rdata;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= REQ_LSU;
      id_q     <= REQ_IFU;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      ifu_rv_q <= 1'b0;
      ifu_rd_q <= '0;
      lsu_rv_q <= 1'b0;
      lsu_rd_q <= '0;
`ifdef MEM_ARB_DELAY_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      ifu_rv_q <= ifu_rv_d;
      ifu_rd_q <= ifu_rd_d;
      lsu_rv_q <= lsu_rv_d;
      lsu_rd_q <= lsu_rd_d;
`ifdef MEM_ARB_DELAY_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single DPI-backed data memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Accepts valid/ready requests from each side and arbitrates between them round-robin.
- Registers each request and drives the memory's combinational ren/addr/wen/wMask/wData for exactly one cycle per access.
- Returns registered read data to the winning requester as a one-cycle response pulse.
- Sits between IFU/LSU and the memory model in the NPC top level.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width; mask width is DATA_W/8.
- DELAY, 2, wait cycles inserted before each access (used only with MEM_ARB_DELAY_EN).

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ifu_req_valid  in  1  IFU read request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  ADDR_W  IFU read address.
- ifu_resp_valid  out  1  one-cycle pulse: ifu_resp_data valid.
- ifu_resp_data  out  DATA_W  fetched data.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_wen  in  1  1 = write, 0 = read.
- lsu_addr  in  ADDR_W  LSU address.
- lsu_wdata  in  DATA_W  write data.
- lsu_wmask  in  DATA_W/8  byte write mask.
- lsu_resp_valid  out  1  one-cycle pulse: read data or write ack.
- lsu_resp_data  out  DATA_W  read data; 0 for write acks.
- mem_ren  out  1  memory read enable.
- mem_wen  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wmask  out  DATA_W/8  memory byte mask.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data (combinational from mem_addr/mem_ren).

Behaviour:
- Reset state:
  - FSM in IDLE; last_grant = LSU, so the IFU wins the first tie.
  - All outputs 0, including both ready signals, both resp_valid pulses and both resp_data values.
- States: IDLE, WAIT (MEM_ARB_DELAY_EN only), ACCESS.
- IDLE:
  - Grant selection: if exactly one requester is valid, it is granted. If both are valid, the requester not equal to last_grant is granted.
  - Ready is combinational: the granted requester sees ready = 1 in IDLE; the other sees 0.
  - On handshake (valid && ready): latch id, addr, wen (forced 0 for IFU), wdata, wmask; update last_grant; go to ACCESS.
- ACCESS: for exactly one cycle, mem_addr = latched address.
  - Read: mem_ren = 1, mem_wen = 0; mem_rdata is captured into the requester's resp_data register at the end of this cycle.
  - Write: mem_wen = 1, mem_ren = 0; mem_wmask/mem_wdata from latched values; resp_data = 0.
  - Next state is IDLE.
- Outside ACCESS: mem_ren = mem_wen = 0; mem_addr/mem_wmask/mem_wdata = 0. No DPI call fires outside ACCESS.
- Response:
  - resp_valid for the granted id pulses high for one cycle, the cycle after ACCESS.
  - resp_data holds its value until the next response to that requester.
  - Responses have no back-pressure; requesters must accept them.
- Latency: handshake at cycle N → ACCESS at N+1 → resp_valid at N+2.
  - In N+2 the FSM is back in IDLE, so a new handshake can occur in the same cycle as the response.
  - Sustained throughput: one access per 2 cycles.
- Request ports are not latched before handshake; requesters hold valid and payload stable until ready.
- Reset asserted mid-operation: FSM returns to IDLE; the pending access is dropped, no response is issued and no memory enable is raised.

Optional Feature:
- MEM_ARB_DELAY_EN defined:
  - After a handshake the FSM enters WAIT, counting DELAY cycles with the enables held low, then enters ACCESS.
  - Latency becomes N+2+DELAY. DELAY = 0 skips WAIT.
  - Ready stays 0 throughout WAIT.
- Undefined: no WAIT state, no counter, DELAY ignored.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, WAIT, ACCESS};
  - requester id enum {REQ_IFU, REQ_LSU};
  - default width constants.
- Sub-module mem_arb_rr: 2-way round-robin picker; inputs two valids and last_grant, outputs grant one-hot.

Test Plan:
- Lone IFU: IFU read at 0x8000_0000, memory holds 0x0000_0013_0000_0297 → ifu_req_ready = 1 at N; mem_ren = 1 at N+1 only; ifu_resp_valid = 1 at N+2 with that data; lsu_resp_valid stays 0.
- LSU write: lsu_wen = 1, addr 0x8000_0100, wdata 0xDEAD_BEEF, wmask 0x0F → mem_wen = 1 for one cycle with mask 0x0F; lsu_resp_valid at N+2 with data 0; a following read of the same address returns 0xDEAD_BEEF in the low 32 bits.
- Tie: both valid continuously from reset → grants alternate IFU, LSU, IFU, LSU; each requester gets one response per 4 cycles.
- Back-to-back: IFU valid continuously → handshakes at N, N+2, N+4; resp pulses at N+2, N+4, N+6.
- Reset during ACCESS: assert reset in the ACCESS cycle → no resp_valid afterwards, mem enables 0 immediately, FSM in IDLE.
- With MEM_ARB_DELAY_EN, DELAY = 3: IFU read → mem_ren at N+4, ifu_resp_valid at N+5; ready = 0 for N+1..N+4.
